// File: rtl/lcd_bus_monitor_if.sv
// Pin-level bundle for the Spartan-3E character-LCD bus plus the monitor's decode results.
// master drives the LCD pins (controller side); slave is the passive monitor.
interface lcd_bus_monitor_if;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned DATA_W = 10;
  localparam int unsigned ERR_W  = 3;

  logic [NIB_W-1:0]  sf_d;
  logic              lcd_e;
  logic              lcd_rs;
  logic              lcd_rw;
  logic              sf_ce0;

  logic              init_done;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              err_valid;
  logic [ERR_W-1:0]  err_code;
  logic              any_err;

  modport master (
    output sf_d, lcd_e, lcd_rs, lcd_rw, sf_ce0,
    input  init_done, data_out, data_valid, err_valid, err_code, any_err
  );

  modport slave (
    input  sf_d, lcd_e, lcd_rs, lcd_rw, sf_ce0,
    output init_done, data_out, data_valid, err_valid, err_code, any_err
  );
endinterface

// File: rtl/lcd_bus_monitor.sv
// Passive monitor for the 4-bit character-LCD bus: decodes the 3,3,3,2 power-up sequence,
// reassembles nibble pairs into {rs, rw, byte} and flags timing/protocol violations.
module lcd_bus_monitor #(
  parameter int unsigned MIN_E_HIGH   = 12,
  parameter int unsigned MIN_NIB_GAP  = 50,
  parameter int unsigned MIN_BYTE_GAP = 2000
) (
  input logic              clk,
  input logic              reset,
  lcd_bus_monitor_if.slave bus
);
  localparam int unsigned GAP_W = 20;
  localparam int unsigned WID_W = 16;
  localparam logic [GAP_W-1:0] GAP_MAX = '1;
  localparam logic [WID_W-1:0] WID_MAX = '1;
  // Counters read zero on the edge cycle itself, so a level lasting N cycles shows N-1 here
  localparam logic [WID_W-1:0] WID_LIM  = WID_W'(MIN_E_HIGH - 1);
  localparam logic [GAP_W-1:0] NIB_LIM  = GAP_W'(MIN_NIB_GAP - 1);
  localparam logic [GAP_W-1:0] BYTE_LIM = GAP_W'(MIN_BYTE_GAP - 1);

  typedef enum logic [1:0] {ST_SYNC, ST_HIGH, ST_LOW} state_t;

  logic             e_q, rs_q, rw_q, ce_q;
  logic [3:0]       d_q;
  state_t           state;
  logic [1:0]       seq_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [WID_W-1:0] wid_cnt;
  logic [3:0]       upper;
  logic             up_rs, up_rw;
  logic             ign;
  logic             chg_seen;

  logic             init_done, data_valid, err_valid, any_err;
  logic [9:0]       data_out;
  logic [2:0]       err_code;

  logic             rise_c, fall_c, act_fall_c, bus_chg_c, gap_short_c;
  logic [3:0]       exp_nib_c;
  logic [7:1]       err_vec_c;
  logic [2:0]       err_sel_c;

  assign bus.init_done  = init_done;
  assign bus.data_out   = data_out;
  assign bus.data_valid = data_valid;
  assign bus.err_valid  = err_valid;
  assign bus.err_code   = err_code;
  assign bus.any_err    = any_err;

  // Edge detection and per-cycle error conditions; lowest code wins
  always_comb begin
    rise_c      = ~e_q & bus.lcd_e;
    fall_c      = e_q & ~bus.lcd_e;
    act_fall_c  = fall_c & ~ign;
    bus_chg_c   = e_q & bus.lcd_e & ~ign &
                  ((bus.sf_d != d_q) | (bus.lcd_rs != rs_q) | (bus.lcd_rw != rw_q));
    gap_short_c = (state == ST_LOW) ? (gap_cnt < NIB_LIM) : (gap_cnt < BYTE_LIM);
    exp_nib_c   = (seq_cnt == 2'd3) ? 4'd2 : 4'd3;

    err_vec_c    = '0;
    err_vec_c[1] = act_fall_c & (wid_cnt < WID_LIM);
    err_vec_c[2] = rise_c & ce_q & (state == ST_LOW) & gap_short_c;
    err_vec_c[3] = rise_c & ce_q & (state != ST_LOW) & gap_short_c;
    err_vec_c[4] = act_fall_c & (state == ST_LOW) & ({rs_q, rw_q} != {up_rs, up_rw});
    err_vec_c[5] = bus_chg_c & ~chg_seen;
    err_vec_c[6] = act_fall_c & (state == ST_SYNC) & (d_q != exp_nib_c);
    err_vec_c[7] = rise_c & ~ce_q;

    err_sel_c = '0;
    for (int i = 7; i >= 1; i--) begin
      if (err_vec_c[i]) err_sel_c = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q        <= 1'b0;
      d_q        <= '0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      ce_q       <= 1'b0;
      state      <= ST_SYNC;
      seq_cnt    <= '0;
      gap_cnt    <= GAP_MAX;
      wid_cnt    <= '0;
      upper      <= '0;
      up_rs      <= 1'b0;
      up_rw      <= 1'b0;
      ign        <= 1'b0;
      chg_seen   <= 1'b0;
      init_done  <= 1'b0;
      data_out   <= 10'h000;
      data_valid <= 1'b0;
      err_valid  <= 1'b0;
      err_code   <= '0;
      any_err    <= 1'b0;
    end else begin
      e_q  <= bus.lcd_e;
      d_q  <= bus.sf_d;
      rs_q <= bus.lcd_rs;
      rw_q <= bus.lcd_rw;
      ce_q <= bus.sf_ce0;

      data_valid <= 1'b0;
      err_valid  <= |err_vec_c;
      if (|err_vec_c) err_code <= err_sel_c;
      any_err <= any_err | (|err_vec_c);

      if (act_fall_c)              gap_cnt <= '0;
      else if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + 1'b1;

      if (rise_c)                          wid_cnt <= '0;
      else if (e_q && (wid_cnt != WID_MAX)) wid_cnt <= wid_cnt + 1'b1;

      // A strobe that starts with the flash still enabled is not LCD traffic
      if (rise_c) begin
        ign      <= ~ce_q;
        chg_seen <= 1'b0;
      end else if (bus_chg_c) begin
        chg_seen <= 1'b1;
      end

      if (act_fall_c) begin
        case (state)
          ST_SYNC: begin
            if (d_q == exp_nib_c) begin
              if (seq_cnt == 2'd3) begin
                state     <= ST_HIGH;
                init_done <= 1'b1;
                seq_cnt   <= '0;
              end else begin
                seq_cnt <= seq_cnt + 2'd1;
              end
            end else begin
              seq_cnt <= (d_q == 4'd3) ? 2'd1 : 2'd0;
            end
          end
          ST_HIGH: begin
            upper <= d_q;
            up_rs <= rs_q;
            up_rw <= rw_q;
            state <= ST_LOW;
          end
          ST_LOW: begin
            data_out   <= {up_rs, up_rw, upper, d_q};
            data_valid <= 1'b1;
            state      <= ST_HIGH;
          end
          default: state <= ST_SYNC;
        endcase
      end
    end
  end
endmodule
